wb_arbiter_nx1: RTL
===================

Name: wb_arbiter_Nx1

Overview:
Shares one Wishbone target port between N_INITIATORS initiators. Grants are round-robin and registered. A grant is held for the full bus cycle (cyc high), so multi-beat cycles are locked to one owner. An optional watchdog aborts transfers the target never answers. Typical use is in front of a single shared slave, such as a memory controller, or in front of an interconnect target port.

Parameters:
WB_ADDR_WIDTH, 32, address width
WB_DATA_WIDTH, 32, data width; must be a multiple of 8
N_INITIATORS, 2, number of requesting initiators (>=1)
TIMEOUT_CYCLES, 256, watchdog limit in cycles (>=2); used only with the optional feature

Ports:
clock  in  1  single clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
adr  in  N_INITIATORS*WB_ADDR_WIDTH  initiator addresses, packed
dat_w  in  N_INITIATORS*WB_DATA_WIDTH  initiator write data
dat_r  out  N_INITIATORS*WB_DATA_WIDTH  read data to initiators
cyc  in  N_INITIATORS  cycle valid
stb  in  N_INITIATORS  strobe
we  in  N_INITIATORS  write enable
sel  in  N_INITIATORS*(WB_DATA_WIDTH/8)  byte selects
ack  out  N_INITIATORS  acknowledge
err  out  N_INITIATORS  error
tadr  out  WB_ADDR_WIDTH  target address
tdat_w  out  WB_DATA_WIDTH  target write data
tdat_r  in  WB_DATA_WIDTH  target read data
tcyc  out  1  target cycle
tstb  out  1  target strobe
twe  out  1  target write enable
tsel  out  WB_DATA_WIDTH/8  target byte selects
tack  in  1  target acknowledge
terr  in  1  target error
gnt  out  N_INITIATORS  registered one-hot grant
timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Request: req[i] = cyc[i] & stb[i].
- State machine: IDLE, BUSY, ABORT. State, gnt, rr_ptr and wdog_cnt are all registered.
- Reset (reset=0, asynchronous):
  - State goes to IDLE; gnt=0, rr_ptr=0, wdog_cnt=0, timeout=0.
  - All target outputs are 0; ack, err and dat_r are 0.
  - Applies mid-transfer as well; any outstanding target response is dropped.
- IDLE, any req set:
  - Pick the first requester scanning upward from rr_ptr, wrapping modulo N_INITIATORS.
  - Register that pick as one-hot gnt and go to BUSY.
  - tcyc/tstb appear the cycle after the request. Arbitration latency is 1 cycle.
- IDLE, no req: stay in IDLE; gnt=0.
- BUSY:
  - tadr, tdat_w, tsel, twe, tcyc and tstb are combinational copies of the granted initiator's signals.
  - ack[g]=tack, err[g]=terr, dat_r[g]=tdat_r. Non-granted initiators see ack=0, err=0, dat_r=0.
  - Other initiators' requests are ignored while the grant is held.
- BUSY, granted cyc falls:
  - gnt clears, rr_ptr = (g+1) mod N_INITIATORS, next state IDLE.
  - A minimum of one idle cycle separates consecutive owners.
- Outside BUSY: all target outputs are 0.
- Requester at rr_ptr wins ties. A just-released initiator has lowest priority in the next arbitration.
- N_INITIATORS=1: rr_ptr is 1 bit and held at 0; grant always goes to initiator 0.
- Simultaneous tack and terr: both are passed through unchanged; the arbiter does not resolve them.

Optional Feature:
WB_ARBITER_TIMEOUT_EN
- Enabled:
  - wdog_cnt width is $clog2(TIMEOUT_CYCLES+1).
  - In BUSY, wdog_cnt increments each cycle with tcyc&tstb&~tack&~terr. It clears on tack, terr, tstb low, or leaving BUSY.
  - When wdog_cnt==TIMEOUT_CYCLES-1 and no tack/terr in that cycle, go to ABORT.
  - If tack/terr arrives on that same cycle, the response wins and no abort occurs.
  - ABORT lasts exactly 1 cycle: tcyc=tstb=0, err[g]=1, ack[g]=0, timeout=1. Any tack/terr during ABORT is ignored.
  - Then gnt clears, rr_ptr advances and state returns to IDLE. An initiator still requesting re-arbitrates normally.
- Disabled: no counter, ABORT is unreachable, timeout is tied to 0.

Decomposition:
- Shared package/include wb_arbiter_pkg holds:
  - state encoding localparams ST_IDLE, ST_BUSY, ST_ABORT;
  - the width helper for rr_ptr (N_INITIATORS>1 ? $clog2(N_INITIATORS) : 1).
- One sub-module: wb_rr_pick. It is purely combinational: given req and rr_ptr, it outputs a one-hot pick and its index.
- The arbiter instantiates wb_rr_pick once. All registers stay in the top module.

Test Plan:
- Single request, N=2: req[0] at cycle 0 → gnt=2'b01 and tstb=1 at cycle 1; tack at cycle 3 → ack[0]=1 in cycle 3; dat_r[0]=tdat_r=32'hDEAD_BEEF.
- Contention: req[0] and req[1] held together from reset → grant order 0,1,0,1, with one idle cycle between owners each time.
- Locked burst: initiator 1 holds cyc for 4 beats (stb toggling) while req[0] is pending → gnt stays 2'b10 until cyc[1] falls; initiator 0 then granted 2 cycles later.
- Timeout, TIMEOUT_CYCLES=4, macro enabled: tack never asserts → err[g]=1 and timeout=1 for one cycle, 4 cycles after tstb rose; tcyc=0 in that cycle; tack on the 4th cycle instead gives ack and no err.
- Reset mid-transfer: reset low during BUSY → tcyc, tstb, gnt and ack go 0 immediately (asynchronously); after release, the first grant goes to initiator 0 (rr_ptr=0).

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared state encoding and width helper for the Wishbone N:1 arbiter
//
// Contents:
//   arb_state_t    arbiter state encoding (ST_IDLE, ST_BUSY, ST_ABORT)
//   rr_ptr_width() width of the round-robin pointer / grant index for n initiators
package wb_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_ABORT = 2'b10
    } arb_state_t;

    // A single initiator still gets a 1-bit pointer so every vector stays non-empty.
    function automatic int rr_ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// rtl/wb_rr_pick.sv - combinational round-robin picker
//
// Ports:
//   req        in   N   request vector
//   rr_ptr     in   PW  index with highest priority
//   pick       out  N   one-hot winner (all zero when no request)
//   pick_idx   out  PW  index of the winner
//   pick_valid out  1   at least one request present
module wb_rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] rr_ptr,
    output logic [N-1:0]  pick,
    output logic [PW-1:0] pick_idx,
    output logic          pick_valid
);

    // Two passes: first the requesters at or above rr_ptr, then the wrapped
    // ones below it. The first hit in scan order wins.
    always_comb begin
        pick       = '0;
        pick_idx   = '0;
        pick_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!pick_valid && req[i] && (i >= int'(rr_ptr))) begin
                pick_valid = 1'b1;
                pick[i]    = 1'b1;
                pick_idx   = PW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!pick_valid && req[i]) begin
                pick_valid = 1'b1;
                pick[i]    = 1'b1;
                pick_idx   = PW'(i);
            end
        end
    end

endmodule

// File: rtl/wb_arbiter_nx1.sv
// rtl/wb_arbiter_nx1.sv - round-robin Wishbone N:1 arbiter with optional watchdog (WB_ARBITER_TIMEOUT_EN)
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   adr/dat_w/sel/we      packed initiator request fields
//   cyc/stb               per-initiator cycle and strobe
//   dat_r/ack/err         per-initiator responses (zero for non-owners)
//   tadr/tdat_w/tsel/twe  target request fields (granted initiator's copy)
//   tcyc/tstb             target cycle and strobe
//   tdat_r/tack/terr      target responses
//   gnt                   registered one-hot grant
//   timeout               one-cycle pulse when the watchdog aborts a transfer
// Build option: define WB_ARBITER_TIMEOUT_EN to include the watchdog.
module wb_arbiter_nx1
    import wb_arbiter_pkg::*;
#(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int N_INITIATORS   = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic [N_INITIATORS*WB_ADDR_WIDTH-1:0]       adr,
    input  logic [N_INITIATORS*WB_DATA_WIDTH-1:0]       dat_w,
    output logic [N_INITIATORS*WB_DATA_WIDTH-1:0]       dat_r,
    input  logic [N_INITIATORS-1:0]                     cyc,
    input  logic [N_INITIATORS-1:0]                     stb,
    input  logic [N_INITIATORS-1:0]                     we,
    input  logic [N_INITIATORS*(WB_DATA_WIDTH/8)-1:0]   sel,
    output logic [N_INITIATORS-1:0]                     ack,
    output logic [N_INITIATORS-1:0]                     err,
    output logic [WB_ADDR_WIDTH-1:0]                    tadr,
    output logic [WB_DATA_WIDTH-1:0]                    tdat_w,
    input  logic [WB_DATA_WIDTH-1:0]                    tdat_r,
    output logic                                        tcyc,
    output logic                                        tstb,
    output logic                                        twe,
    output logic [WB_DATA_WIDTH/8-1:0]                  tsel,
    input  logic                                        tack,
    input  logic                                        terr,
    output logic [N_INITIATORS-1:0]                     gnt,
    output logic                                        timeout
);

    localparam int SW = WB_DATA_WIDTH / 8;
    localparam int PW = rr_ptr_width(N_INITIATORS);

    arb_state_t            state;
    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         g_idx;
    logic [PW-1:0]         next_ptr;
    logic [N_INITIATORS-1:0] req;
    logic [N_INITIATORS-1:0] pick;
    logic [PW-1:0]         pick_idx;
    logic                  pick_valid;
    logic                  wdog_expire;

    assign req = cyc & stb;

    // The released owner moves to the back of the queue.
    assign next_ptr = (int'(g_idx) == N_INITIATORS - 1) ? '0 : g_idx + 1'b1;

    wb_rr_pick #(
        .N  (N_INITIATORS),
        .PW (PW)
    ) u_pick (
        .req        (req),
        .rr_ptr     (rr_ptr),
        .pick       (pick),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    // Target side is a pure mux of the owner; nothing leaks out while idle or aborting.
    always_comb begin
        tadr   = '0;
        tdat_w = '0;
        tsel   = '0;
        twe    = 1'b0;
        tcyc   = 1'b0;
        tstb   = 1'b0;
        ack    = '0;
        err    = '0;
        dat_r  = '0;
        if (state == ST_BUSY) begin
            tadr   = adr[int'(g_idx)*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
            tdat_w = dat_w[int'(g_idx)*WB_DATA_WIDTH +: WB_DATA_WIDTH];
            tsel   = sel[int'(g_idx)*SW +: SW];
            twe    = we[g_idx];
            tcyc   = cyc[g_idx];
            tstb   = stb[g_idx];
            ack[g_idx] = tack;
            err[g_idx] = terr;
            dat_r[int'(g_idx)*WB_DATA_WIDTH +: WB_DATA_WIDTH] = tdat_r;
        end else if (state == ST_ABORT) begin
            err[g_idx] = 1'b1;
        end
    end

`ifdef WB_ARBITER_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYCLES - 1);

    logic [WW-1:0] wdog_cnt;
    logic          stalled;
    logic          timeout_q;

    assign stalled     = tcyc & tstb & ~tack & ~terr;
    // A response arriving on the last allowed cycle clears 'stalled', so it wins.
    assign wdog_expire = (state == ST_BUSY) && stalled && (wdog_cnt == WDOG_LAST);
    assign timeout     = timeout_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wdog_cnt <= '0;
        end else if ((state == ST_BUSY) && stalled && !wdog_expire) begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end else begin
            wdog_cnt <= '0;
        end
    end
`else
    // Watchdog compiled out; TIMEOUT_CYCLES only keeps the parameter list common to both builds.
    assign wdog_expire = 1'b0;
    assign timeout     = (TIMEOUT_CYCLES > 0) ? 1'b0 : 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            gnt    <= '0;
            g_idx  <= '0;
            rr_ptr <= '0;
`ifdef WB_ARBITER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef WB_ARBITER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        gnt   <= pick;
                        g_idx <= pick_idx;
                        state <= ST_BUSY;
                    end else begin
                        gnt <= '0;
                    end
                end
                ST_BUSY: begin
                    // Grant is held for the whole cycle, not per strobe.
                    if (!cyc[g_idx]) begin
                        gnt    <= '0;
                        rr_ptr <= next_ptr;
                        state  <= ST_IDLE;
                    end else if (wdog_expire) begin
                        state <= ST_ABORT;
`ifdef WB_ARBITER_TIMEOUT_EN
                        timeout_q <= 1'b1;
`endif
                    end
                end
                ST_ABORT: begin
                    gnt    <= '0;
                    rr_ptr <= next_ptr;
                    state  <= ST_IDLE;
                end
                default: begin
                    gnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
